// File: rtl/muldiv_unit_if.sv
// Handshake bundle between the execute stage and the multiply/divide unit.
// Request side: in_valid/in_ready/op/src1/src2; response side: out_valid/out_ready/result.
interface muldiv_unit_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;

  modport master (
    output in_valid, op, src1, src2, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, op, src1, src2, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit: shift-add multiply, restoring divide.
// Ports: clk, reset (sync, active-high), flush, bus (muldiv_unit_if.slave).
module muldiv_unit #(
  parameter int WIDTH          = 64,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  muldiv_unit_if.slave bus
);
  localparam int ITER = WIDTH / BITS_PER_CYCLE;
  localparam int BPC  = BITS_PER_CYCLE;
  localparam int CW   = $clog2(ITER + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic [3:0]         op_q, op_d;
  logic               negq_q, negq_d;
  logic               negr_q, negr_d;
  logic [WIDTH-1:0]   res_q, res_d;

  function automatic logic [WIDTH-1:0] wfix(
    input logic [WIDTH-1:0] v,
    input logic             w
  );
    return w ? {{(WIDTH-32){v[31]}}, v[31:0]} : v;
  endfunction

  // Operand preparation at accept time
  logic             w_in;
  logic [2:0]       code_in;
  logic             a_sgn, b_sgn;
  logic [WIDTH-1:0] a_ext, b_ext;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] min_in;
  logic             div_zero, ovf, special;
  logic [WIDTH-1:0] spec_raw;
  logic             accept;

  assign w_in    = bus.op[3];
  assign code_in = bus.op[2:0];
  assign a_sgn   = (code_in == 3'd1) | (code_in == 3'd2)
                 | (code_in == 3'd4) | (code_in == 3'd6);
  assign b_sgn   = (code_in == 3'd1) | (code_in == 3'd4)
                 | (code_in == 3'd6);

  always_comb begin
    a_ext = bus.src1;
    b_ext = bus.src2;
    if (w_in) begin
      a_ext = {{(WIDTH-32){a_sgn & bus.src1[31]}},
               bus.src1[31:0]};
      b_ext = {{(WIDTH-32){b_sgn & bus.src2[31]}},
               bus.src2[31:0]};
    end
  end

  // Magnitudes feed an unsigned datapath; signs are reapplied at the end.
  assign a_neg = a_sgn & a_ext[WIDTH-1];
  assign b_neg = b_sgn & b_ext[WIDTH-1];
  assign a_mag = a_neg ? -a_ext : a_ext;
  assign b_mag = b_neg ? -b_ext : b_ext;

  // Most negative value at the operating width, as seen after extension
  assign min_in = w_in ? {{(WIDTH-31){1'b1}}, 31'b0}
                       : {1'b1, {(WIDTH-1){1'b0}}};

  assign div_zero = (b_ext == '0);
  assign ovf      = ~code_in[0] & (a_ext == min_in)
                  & (b_ext == '1);
  assign special  = code_in[2] & (div_zero | ovf);

  always_comb begin
    if (code_in[1])
      spec_raw = div_zero ? a_ext : '0;
    else
      spec_raw = div_zero ? '1 : a_ext;
  end

  assign accept = (state_q == S_IDLE) & bus.in_valid & ~flush;

  // One iteration of either datapath
  logic [2*WIDTH-1:0] mul_nx, div_nx, iter_nx;

  always_comb begin : iter_c
    logic [WIDTH+BPC-1:0] part;
    logic [WIDTH+BPC-1:0] hi;
    logic [WIDTH:0]       t;
    logic [WIDTH-1:0]     r;
    logic [WIDTH-1:0]     q;
    part = '0;
    for (int i = 0; i < BPC; i++) begin
      if (p_q[i])
        part = part + ({{BPC{1'b0}}, d_q} << i);
    end
    hi     = {{BPC{1'b0}}, p_q[2*WIDTH-1:WIDTH]} + part;
    mul_nx = {hi, p_q[WIDTH-1:BPC]};
    r = p_q[2*WIDTH-1:WIDTH];
    q = p_q[WIDTH-1:0];
    for (int i = 0; i < BPC; i++) begin
      t = {r, q[WIDTH-1]};
      q = {q[WIDTH-2:0], 1'b0};
      if (t >= {1'b0, d_q}) begin
        t    = t - {1'b0, d_q};
        q[0] = 1'b1;
      end
      r = t[WIDTH-1:0];
    end
    div_nx  = {r, q};
    iter_nx = op_q[2] ? div_nx : mul_nx;
  end

  // Sign fix-up and W extension of the final iteration
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   qv, rv, raw, fin_res;
  logic               illegal;

  always_comb begin
    prod = negq_q ? -iter_nx : iter_nx;
    qv   = negq_q ? -iter_nx[WIDTH-1:0]
                  : iter_nx[WIDTH-1:0];
    rv   = negr_q ? -iter_nx[2*WIDTH-1:WIDTH]
                  : iter_nx[2*WIDTH-1:WIDTH];
    if (op_q[2])
      raw = op_q[1] ? rv : qv;
    else if (op_q[1:0] == 2'd0)
      raw = prod[WIDTH-1:0];
    else
      raw = prod[2*WIDTH-1:WIDTH];
    illegal = op_q[3] & ~op_q[2] & (op_q[1:0] != 2'd0);
    fin_res = illegal ? '0 : wfix(raw, op_q[3]);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    d_d     = d_q;
    op_d    = op_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    res_d   = res_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d   = bus.op;
          negq_d = a_neg ^ b_neg;
          negr_d = a_neg;
          if (special) begin
            res_d   = wfix(spec_raw, w_in);
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            state_d = S_BUSY;
            cnt_d   = CW'(ITER);
            d_d     = code_in[2] ? b_mag : a_mag;
            p_d     = {{WIDTH{1'b0}},
                       code_in[2] ? a_mag : b_mag};
          end
        end
      end
      S_BUSY: begin
        p_d   = iter_nx;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          res_d   = fin_res;
        end
      end
      S_DONE: begin
        if (bus.out_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Redirect wins over any accept or result hand-off
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      d_q     <= '0;
      op_q    <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      d_q     <= d_d;
      op_q    <= op_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      res_q   <= res_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = res_q;

endmodule
